// File: rtl/dec_8b10b_pkg.sv
// Shared types and constants for the 8b/10b receive decoder and sync monitor.
package dec_8b10b_pkg;

    typedef enum logic [1:0] {
        LOS  = 2'd0,
        CHK  = 2'd1,
        SYNC = 2'd2
    } sync_state_t;

    // K28 6b sub-blocks; these are the only 6b patterns a comma can start with
    localparam logic [5:0] K28_6B_RDN = 6'b001111;
    localparam logic [5:0] K28_6B_RDP = 6'b110000;

    // K28.5 full symbols for each entering running disparity
    localparam logic [9:0] K28_5_RDN = 10'h0FA;
    localparam logic [9:0] K28_5_RDP = 10'h305;

endpackage

// File: rtl/dec_lut_8b10b.sv
// Combinational 10b/8b lookup: decoded byte, K flag, code/disparity errors, next RD.
// Disparity checking is compiled in only when DEC_DISP_CHK_EN is defined.
module dec_lut_8b10b
    import dec_8b10b_pkg::*;
(
    input  logic [9:0] symbol,
    input  logic       rd_in,
    output logic [7:0] data,
    output logic       k,
    output logic       code_err,
    output logic       disp_err,
    output logic       rd_out
);

    logic [5:0] sb6;
    logic [3:0] sb4;
    logic [3:0] fb4;
    logic [4:0] val5;
    logic [2:0] val3;
    logic       ok6;
    logic       ok4;
    logic       p7;
    logic       a7;
    logic       k28;
    logic       kx7_6b;
    logic       a7_data_6b;
    logic [2:0] ones6;
    logic [2:0] ones4;
    logic       rd6;

    assign sb6   = symbol[9:4];
    assign sb4   = symbol[3:0];
    assign ones6 = 3'($countones(sb6));
    assign ones4 = 3'($countones(sb4));
    assign k28   = (sb6 == K28_6B_RDN) || (sb6 == K28_6B_RDP);
    // The RD+ form of K28 is the full complement, so its 4b decodes inverted
    assign fb4   = (sb6 == K28_6B_RDP) ? ~sb4 : sb4;

    // 6b sub-block to EDCBA
    always_comb begin
        val5 = 5'd0;
        ok6  = 1'b1;
        case (sb6)
            6'b100111, 6'b011000: val5 = 5'd0;
            6'b011101, 6'b100010: val5 = 5'd1;
            6'b101101, 6'b010010: val5 = 5'd2;
            6'b110001:            val5 = 5'd3;
            6'b110101, 6'b001010: val5 = 5'd4;
            6'b101001:            val5 = 5'd5;
            6'b011001:            val5 = 5'd6;
            6'b111000, 6'b000111: val5 = 5'd7;
            6'b111001, 6'b000110: val5 = 5'd8;
            6'b100101:            val5 = 5'd9;
            6'b010101:            val5 = 5'd10;
            6'b110100:            val5 = 5'd11;
            6'b001101:            val5 = 5'd12;
            6'b101100:            val5 = 5'd13;
            6'b011100:            val5 = 5'd14;
            6'b010111, 6'b101000: val5 = 5'd15;
            6'b011011, 6'b100100: val5 = 5'd16;
            6'b100011:            val5 = 5'd17;
            6'b010011:            val5 = 5'd18;
            6'b110010:            val5 = 5'd19;
            6'b001011:            val5 = 5'd20;
            6'b101010:            val5 = 5'd21;
            6'b011010:            val5 = 5'd22;
            6'b111010, 6'b000101: val5 = 5'd23;
            6'b110011, 6'b001100: val5 = 5'd24;
            6'b100110:            val5 = 5'd25;
            6'b010110:            val5 = 5'd26;
            6'b110110, 6'b001001: val5 = 5'd27;
            6'b001110:            val5 = 5'd28;
            6'b001111, 6'b110000: val5 = 5'd28;
            6'b101110, 6'b010001: val5 = 5'd29;
            6'b011110, 6'b100001: val5 = 5'd30;
            6'b101011, 6'b010100: val5 = 5'd31;
            default:              ok6  = 1'b0;
        endcase
    end

    // 4b sub-block to HGF, separating primary and alternate x.7 forms
    always_comb begin
        val3 = 3'd0;
        ok4  = 1'b1;
        p7   = 1'b0;
        a7   = 1'b0;
        case (fb4)
            4'b1011, 4'b0100: val3 = 3'd0;
            4'b1001:          val3 = 3'd1;
            4'b0101:          val3 = 3'd2;
            4'b1100, 4'b0011: val3 = 3'd3;
            4'b1101, 4'b0010: val3 = 3'd4;
            4'b1010:          val3 = 3'd5;
            4'b0110:          val3 = 3'd6;
            4'b1110, 4'b0001: begin val3 = 3'd7; p7 = 1'b1; end
            4'b0111, 4'b1000: begin val3 = 3'd7; a7 = 1'b1; end
            default:          ok4  = 1'b0;
        endcase
    end

    // 6b codes that may carry the alternate x.7: K23/K27/K29/K30 and D11/13/14/17/18/20
    always_comb begin
        kx7_6b     = 1'b0;
        a7_data_6b = 1'b0;
        case (sb6)
            6'b111010, 6'b000101, 6'b110110, 6'b001001,
            6'b101110, 6'b010001, 6'b011110, 6'b100001: kx7_6b = 1'b1;
            6'b110100, 6'b101100, 6'b011100,
            6'b100011, 6'b010011, 6'b001011:            a7_data_6b = 1'b1;
            default: ;
        endcase
    end

    // Table membership, K classification and byte assembly
    always_comb begin
        code_err = ~ok6 | ~ok4 | (a7 & ~(k28 | kx7_6b | a7_data_6b)) | (p7 & k28);
        k        = ~code_err & (k28 | (kx7_6b & a7));
        data     = code_err ? 8'h00 : {val3, val5};
    end

    // Running disparity: each non-neutral sub-block flips RD, 6b first
    assign rd6    = (ones6 != 3'd3) ? ~rd_in : rd_in;
    assign rd_out = (ones4 != 3'd2) ? ~rd6 : rd6;

`ifdef DEC_DISP_CHK_EN
    logic viol6;
    logic viol4;

    // Positive sub-blocks are illegal at RD+, negative ones at RD-
    always_comb begin
        viol6    = ( rd_in & ((ones6 == 3'd4) || (sb6 == 6'b111000))) |
                   (~rd_in & ((ones6 == 3'd2) || (sb6 == 6'b000111)));
        viol4    = ( rd6 & ((ones4 == 3'd3) || (sb4 == 4'b1100))) |
                   (~rd6 & ((ones4 == 3'd1) || (sb4 == 4'b0011)));
        disp_err = viol6 | viol4;
    end
`else
    assign disp_err = 1'b0;
`endif

endmodule

// File: rtl/dec_8b10b_sync.sv
// Registered 10b/8b decoder with running-disparity tracking and link-sync state machine.
// Optional build macro: DEC_DISP_CHK_EN enables disparity error checking.
module dec_8b10b_sync
    import dec_8b10b_pkg::*;
#(
    parameter int unsigned GOOD_CNT = 4,
    parameter int unsigned ERR_MAX  = 3,
    parameter int unsigned HEAL_CNT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [9:0] datain,
    output logic       out_valid,
    output logic [7:0] dataout,
    output logic       kout,
    output logic       code_err,
    output logic       disp_err,
    output logic       rdisp,
    output logic       sync
);

    localparam int unsigned GW = $clog2(GOOD_CNT + 1);
    localparam int unsigned EW = $clog2(ERR_MAX + 1);
    localparam int unsigned HW = $clog2(HEAL_CNT + 1);

    logic [7:0]    lut_data;
    logic          lut_k;
    logic          lut_code_err;
    logic          lut_disp_err;
    logic          lut_rd;
    logic          sym_err;
    logic          comma;
    sync_state_t   state;
    logic [GW-1:0] good_cnt;
    logic [EW-1:0] err_cnt;
    logic [HW-1:0] heal_cnt;

    dec_lut_8b10b u_lut (
        .symbol   (datain),
        .rd_in    (rdisp),
        .data     (lut_data),
        .k        (lut_k),
        .code_err (lut_code_err),
        .disp_err (lut_disp_err),
        .rd_out   (lut_rd)
    );

    // Symbol classification for the sync machine
    always_comb begin
        sym_err = lut_code_err | lut_disp_err;
        comma   = ((datain[9:4] == K28_6B_RDN) || (datain[9:4] == K28_6B_RDP)) &&
                  lut_k && !sym_err &&
                  ((lut_data[7:5] == 3'd1) || (lut_data[7:5] == 3'd5) || (lut_data[7:5] == 3'd7));
    end

    // Output register stage; everything but out_valid holds on idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dataout   <= 8'h00;
            kout      <= 1'b0;
            code_err  <= 1'b0;
            disp_err  <= 1'b0;
            rdisp     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                dataout  <= lut_data;
                kout     <= lut_k;
                code_err <= lut_code_err;
                disp_err <= lut_disp_err;
                rdisp    <= lut_rd;
            end
        end
    end

    // Link sync state machine with lock, error accumulation and healing
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOS;
            sync     <= 1'b0;
            good_cnt <= '0;
            err_cnt  <= '0;
            heal_cnt <= '0;
        end else if (in_valid) begin
            case (state)
                LOS: begin
                    if (comma) begin
                        state    <= CHK;
                        good_cnt <= '0;
                    end
                end
                CHK: begin
                    if (sym_err) begin
                        state    <= LOS;
                        good_cnt <= '0;
                    end else if (good_cnt == GW'(GOOD_CNT - 1)) begin
                        state    <= SYNC;
                        sync     <= 1'b1;
                        good_cnt <= '0;
                        err_cnt  <= '0;
                        heal_cnt <= '0;
                    end else begin
                        good_cnt <= good_cnt + GW'(1);
                    end
                end
                SYNC: begin
                    if (sym_err) begin
                        heal_cnt <= '0;
                        if (err_cnt == EW'(ERR_MAX - 1)) begin
                            state    <= LOS;
                            sync     <= 1'b0;
                            err_cnt  <= '0;
                            good_cnt <= '0;
                        end else begin
                            err_cnt <= err_cnt + EW'(1);
                        end
                    end else if (heal_cnt == HW'(HEAL_CNT - 1)) begin
                        heal_cnt <= '0;
                        if (err_cnt != '0) begin
                            err_cnt <= err_cnt - EW'(1);
                        end
                    end else begin
                        heal_cnt <= heal_cnt + HW'(1);
                    end
                end
                default: begin
                    state <= LOS;
                    sync  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_8b10b_sync.sv
// Directed bench for dec_8b10b_sync: decode, disparity, code errors, lock, loss and healing.
module tb_dec_8b10b_sync;
    import dec_8b10b_pkg::*;

`ifdef DEC_DISP_CHK_EN
    localparam logic DCHK = 1'b1;
`else
    localparam logic DCHK = 1'b0;
`endif

    localparam logic [9:0] D21_5 = 10'h2AA;
    localparam logic [9:0] BAD   = 10'h000;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [9:0] datain;
    logic       out_valid;
    logic [7:0] dataout;
    logic       kout;
    logic       code_err;
    logic       disp_err;
    logic       rdisp;
    logic       sync;

    int vec_cnt;
    int miscompares;

    dec_8b10b_sync dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .datain    (datain),
        .out_valid (out_valid),
        .dataout   (dataout),
        .kout      (kout),
        .code_err  (code_err),
        .disp_err  (disp_err),
        .rdisp     (rdisp),
        .sync      (sync)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [9:0] sym);
        in_valid = 1'b1;
        datain   = sym;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        datain   = 10'h000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Comma then GOOD_CNT neutral data symbols; ends in SYNC with RD+
    task automatic lock_link();
        do_reset();
        send(K28_5_RDN);
        repeat (4) send(D21_5);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        datain   = K28_5_RDN;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++;
        if ({out_valid, dataout, kout, code_err, disp_err, rdisp, sync} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h exp 0", {out_valid, dataout, kout, code_err, disp_err, rdisp, sync});
        end
        rst = 1'b0;
    endtask

    task automatic test_k28_5();
        do_reset();
        send(K28_5_RDN);
        vec_cnt++;
        if ({out_valid, dataout, kout, code_err, disp_err, rdisp} !== {1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL k28_5_rdn got v=%b d=%h k=%b ce=%b de=%b rd=%b exp v=1 d=bc k=1 ce=0 de=0 rd=1",
                     out_valid, dataout, kout, code_err, disp_err, rdisp);
        end
        send(K28_5_RDN);
        vec_cnt++;
        if ({disp_err, rdisp, dataout} !== {DCHK, 1'b0, 8'hBC}) begin
            miscompares++;
            $display("FAIL k28_5_repeat got de=%b rd=%b d=%h exp de=%b rd=0 d=bc", disp_err, rdisp, dataout, DCHK);
        end
        send(K28_5_RDP);
        vec_cnt++;
        if ({disp_err, rdisp} !== {DCHK, 1'b1}) begin
            miscompares++;
            $display("FAIL k28_5_rdp_at_rdn got de=%b rd=%b exp de=%b rd=1", disp_err, rdisp, DCHK);
        end
        send(K28_5_RDP);
        vec_cnt++;
        if ({dataout, kout, disp_err, rdisp} !== {8'hBC, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL k28_5_rdp_at_rdp got d=%h k=%b de=%b rd=%b exp d=bc k=1 de=0 rd=0", dataout, kout, disp_err, rdisp);
        end
    endtask

    task automatic test_data();
        do_reset();
        send(10'h274);
        vec_cnt++;
        if ({dataout, kout, code_err, disp_err, rdisp} !== {8'h00, 4'b0000}) begin
            miscompares++;
            $display("FAIL d0_0 got d=%h k=%b ce=%b de=%b rd=%b exp d=00 k=0 ce=0 de=0 rd=0", dataout, kout, code_err, disp_err, rdisp);
        end
        send(D21_5);
        vec_cnt++;
        if ({dataout, kout, code_err, rdisp} !== {8'hB5, 3'b000}) begin
            miscompares++;
            $display("FAIL d21_5 got d=%h k=%b ce=%b rd=%b exp d=b5 k=0 ce=0 rd=0", dataout, kout, code_err, rdisp);
        end
        send(10'h3A8);
        vec_cnt++;
        if ({dataout, kout, code_err, disp_err, rdisp} !== {8'hF7, 1'b1, 3'b000}) begin
            miscompares++;
            $display("FAIL k23_7 got d=%h k=%b ce=%b de=%b rd=%b exp d=f7 k=1 ce=0 de=0 rd=0", dataout, kout, code_err, disp_err, rdisp);
        end
    endtask

    task automatic test_idle_hold();
        do_reset();
        send(D21_5);
        in_valid = 1'b0;
        datain   = BAD;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++;
        if ({out_valid, dataout, code_err, rdisp} !== {1'b0, 8'hB5, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL idle_hold got v=%b d=%h ce=%b rd=%b exp v=0 d=b5 ce=0 rd=0", out_valid, dataout, code_err, rdisp);
        end
    endtask

    task automatic test_code_err();
        do_reset();
        send(BAD);
        vec_cnt++;
        if ({code_err, dataout, kout, rdisp} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL code_err_000 got ce=%b d=%h k=%b rd=%b exp ce=1 d=00 k=0 rd=0", code_err, dataout, kout, rdisp);
        end
        send(10'h3FF);
        vec_cnt++;
        if ({code_err, dataout, kout} !== {1'b1, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL code_err_3ff got ce=%b d=%h k=%b exp ce=1 d=00 k=0", code_err, dataout, kout);
        end
    endtask

    task automatic test_lock();
        do_reset();
        send(K28_5_RDN);
        repeat (3) send(D21_5);
        vec_cnt++;
        if (sync !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_early got sync=%b exp 0", sync);
        end
        send(D21_5);
        vec_cnt++;
        if (sync !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_fourth got sync=%b exp 1", sync);
        end
    endtask

    task automatic test_chk_error();
        do_reset();
        send(K28_5_RDN);
        repeat (2) send(D21_5);
        send(BAD);
        repeat (4) send(D21_5);
        vec_cnt++;
        if (sync !== 1'b0) begin
            miscompares++;
            $display("FAIL chk_error_to_los got sync=%b exp 0", sync);
        end
        send(K28_5_RDP);
        repeat (4) send(D21_5);
        vec_cnt++;
        if (sync !== 1'b1) begin
            miscompares++;
            $display("FAIL chk_relock got sync=%b exp 1", sync);
        end
    endtask

    task automatic test_loss();
        lock_link();
        send(BAD);
        repeat (5) send(D21_5);
        send(BAD);
        vec_cnt++;
        if (sync !== 1'b1) begin
            miscompares++;
            $display("FAIL loss_second_err got sync=%b exp 1", sync);
        end
        repeat (5) send(D21_5);
        send(BAD);
        vec_cnt++;
        if (sync !== 1'b0) begin
            miscompares++;
            $display("FAIL loss_third_err got sync=%b exp 0", sync);
        end
        lock_link();
        send(BAD);
        repeat (15) send(D21_5);
        send(BAD);
        repeat (15) send(D21_5);
        send(BAD);
        vec_cnt++;
        if (sync !== 1'b0) begin
            miscompares++;
            $display("FAIL loss_spacing_15 got sync=%b exp 0", sync);
        end
    endtask

    task automatic test_heal();
        lock_link();
        send(BAD);
        repeat (16) send(D21_5);
        send(BAD);
        repeat (16) send(D21_5);
        send(BAD);
        vec_cnt++;
        if (sync !== 1'b1) begin
            miscompares++;
            $display("FAIL heal_spacing_16 got sync=%b exp 1", sync);
        end
        send(BAD);
        vec_cnt++;
        if (sync !== 1'b1) begin
            miscompares++;
            $display("FAIL heal_err_cnt_two got sync=%b exp 1", sync);
        end
        send(BAD);
        vec_cnt++;
        if (sync !== 1'b0) begin
            miscompares++;
            $display("FAIL heal_err_cnt_three got sync=%b exp 0", sync);
        end
    endtask

    task automatic test_reset_mid_sync();
        lock_link();
        rst      = 1'b1;
        in_valid = 1'b1;
        datain   = D21_5;
        @(posedge clk);
        #1;
        vec_cnt++;
        if ({out_valid, dataout, kout, code_err, disp_err, rdisp, sync} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_mid_sync got %h exp 0", {out_valid, dataout, kout, code_err, disp_err, rdisp, sync});
        end
        rst = 1'b0;
    endtask

    initial begin
        vec_cnt     = 0;
        miscompares = 0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        datain      = 10'h000;
        #2;
        test_reset();
        test_k28_5();
        test_data();
        test_idle_hold();
        test_code_err();
        test_lock();
        test_chk_error();
        test_loss();
        test_heal();
        test_reset_mid_sync();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
